// File: rtl/hamming74_serial_rx.sv
// Serial Hamming(7,4) receiver: deserialises c1..c7, corrects single-bit errors, presents 4-bit data.
// Output registered one edge after c7; with HOLD_UNTIL_READY a frame decoded while output is held unconsumed is dropped.
module hamming74_serial_rx #(
  parameter bit HOLD_UNTIL_READY = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       serialIn,
  input  logic       bitValid,
  input  logic       frameStart,
  input  logic       dataReady,
  input  logic       clearFlags,
  output logic [3:0] dataOut,
  output logic       dataValid,
  output logic [2:0] syndrome,
  output logic       errCorrected,
  output logic       overflow,
  output logic       frameAbort
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    DECODE = 2'd2
  } state_t;

  state_t      r_state;
  logic [6:0]  r_shift;   // r_shift[k-1] holds ck
  logic [2:0]  r_count;

  logic        w_start;
  logic [2:0]  w_syn;
  logic [6:0]  w_flip;
  logic [6:0]  w_cor;
  logic        w_drop;

  assign w_start = bitValid & frameStart;

  assign w_syn[0] = r_shift[0] ^ r_shift[2] ^ r_shift[4] ^ r_shift[6];
  assign w_syn[1] = r_shift[1] ^ r_shift[2] ^ r_shift[5] ^ r_shift[6];
  assign w_syn[2] = r_shift[3] ^ r_shift[4] ^ r_shift[5] ^ r_shift[6];

  always_comb begin
    w_flip = '0;
    if (w_syn != 3'd0) w_flip[w_syn - 3'd1] = 1'b1;
  end

  assign w_cor  = r_shift ^ w_flip;
  assign w_drop = HOLD_UNTIL_READY && dataValid && !dataReady;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_shift      <= '0;
      r_count      <= '0;
      dataOut      <= '0;
      dataValid    <= 1'b0;
      syndrome     <= '0;
      errCorrected <= 1'b0;
      overflow     <= 1'b0;
      frameAbort   <= 1'b0;
    end else begin
      // Clears first so that a set event later in this block wins.
      if (clearFlags) begin
        overflow   <= 1'b0;
        frameAbort <= 1'b0;
      end
      if (!HOLD_UNTIL_READY) dataValid <= 1'b0;
      else if (dataValid && dataReady) dataValid <= 1'b0;

      case (r_state)
        IDLE: begin
          if (w_start) begin
            r_shift <= {6'b0, serialIn};
            r_count <= 3'd1;
            r_state <= SHIFT;
          end
        end
        SHIFT: begin
          if (w_start) begin
            frameAbort <= 1'b1;
            r_shift    <= {6'b0, serialIn};
            r_count    <= 3'd1;
          end else if (bitValid) begin
            r_shift[r_count] <= serialIn;
            if (r_count == 3'd6) begin
              r_count <= 3'd0;
              r_state <= DECODE;
            end else begin
              r_count <= r_count + 3'd1;
            end
          end
        end
        DECODE: begin
          if (w_drop) begin
            overflow <= 1'b1;
          end else begin
            dataOut      <= {w_cor[2], w_cor[4], w_cor[5], w_cor[6]};
            syndrome     <= w_syn;
            errCorrected <= (w_syn != 3'd0);
            dataValid    <= 1'b1;
          end
          if (w_start) begin
            r_shift <= {6'b0, serialIn};
            r_count <= 3'd1;
            r_state <= SHIFT;
          end else begin
            r_count <= 3'd0;
            r_state <= IDLE;
          end
        end
        default: begin
          r_count <= 3'd0;
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule
